// File: rtl/fetch_byte_streamer_pkg.sv
// Shared types and constants for the fetch byte streamer and its word FIFO.
package fetch_byte_streamer_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int WORD_BYTES = 4;
    localparam int OFF_W      = $clog2(WORD_BYTES);

    typedef logic [ADDR_W_DEF-1:0]   addr_t;
    typedef logic [8*WORD_BYTES-1:0] word_t;
    typedef logic [7:0]              byte_t;
    typedef logic [OFF_W-1:0]        off_t;

endpackage

// File: rtl/fetch_word_fifo.sv
// Small word FIFO between the memory response port and the byte picker.
// Head is read combinationally so the current byte is available every cycle.
module fetch_word_fifo
    import fetch_byte_streamer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     flush,
    input  logic                     push,
    input  word_t                    push_word,
    input  logic                     pop,
    output word_t                    head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    word_t             mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    // Storage write; data words need no reset since count gates their use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= push_word;
        end
    end

    // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fetch_byte_streamer.sv
// Fetches aligned words from instruction memory and streams one byte per
// cycle with its pc to decode. Redirects flush the buffer and drop any
// in-flight response. Optional macro FETCH_BYPASS_EN lets a response word
// feed the byte output in the same cycle when the buffer is empty.
module fetch_byte_streamer
    import fetch_byte_streamer_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                BUF_WORDS = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic [7:0]        inst,
    output logic [ADDR_W-1:0] pc,
    output logic              valid,
    input  logic              ready
);

    localparam int                CNT_W      = $clog2(BUF_WORDS) + 1;
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(BUF_WORDS);
    localparam int                WA_W       = ADDR_W - OFF_W;
    localparam off_t              LAST_OFF   = off_t'(WORD_BYTES - 1);

    logic [WA_W-1:0]   req_word_reg;
    logic [ADDR_W-1:0] out_pc_reg;
    off_t              byte_off_reg;
    logic              outstanding_reg;
    logic              discard_reg;

    word_t             fifo_head;
    word_t             head_word;
    logic [CNT_W-1:0]  buf_count;
    logic              buf_empty;
    logic              buf_full;
    logic              grant;
    logic              resp;
    logic              accept_word;
    logic              bypass_hit;
    logic              fire;
    logic              last_byte;
    logic              push;
    logic              pop;
    byte_t             lane [WORD_BYTES];

    assign buf_empty = (buf_count == '0);
    assign buf_full  = (buf_count == FULL_COUNT);

    // Only one fetch in flight; a redirect cycle never issues.
    assign mem_req  = !rst && !outstanding_reg && !buf_full && !redirect_valid;
    assign mem_addr = {req_word_reg, {OFF_W{1'b0}}};
    assign grant    = mem_req & mem_gnt;

    // Responses without a request in flight are ignored; stale ones dropped.
    assign resp        = mem_rvalid & outstanding_reg;
    assign accept_word = resp & !discard_reg & !redirect_valid;

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = accept_word & buf_empty;
    assign head_word  = buf_empty ? mem_rdata : fifo_head;
`else
    assign bypass_hit = 1'b0;
    assign head_word  = fifo_head;
`endif

    // Little-endian byte lanes of the current head word.
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
        assign lane[gi] = head_word[8*gi +: 8];
    end

    assign inst      = lane[byte_off_reg];
    assign pc        = out_pc_reg;
    assign valid     = !rst && (!buf_empty || bypass_hit) && !redirect_valid;
    assign fire      = valid & ready;
    assign last_byte = (byte_off_reg == LAST_OFF);

    // A bypassed word whose last byte is consumed immediately is never stored.
    assign pop  = fire & last_byte & !buf_empty;
    assign push = accept_word & !(bypass_hit & fire & last_byte);

    fetch_word_fifo #(
        .DEPTH (BUF_WORDS)
    ) u_fifo (
        .clk       (clk),
        .srst      (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_word (mem_rdata),
        .pop       (pop),
        .head      (fifo_head),
        .count     (buf_count)
    );

    // Fetch pointer, output pc/offset, in-flight and discard tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_word_reg    <= RESET_PC[ADDR_W-1:OFF_W];
            out_pc_reg      <= RESET_PC;
            byte_off_reg    <= RESET_PC[OFF_W-1:0];
            outstanding_reg <= 1'b0;
            discard_reg     <= 1'b0;
        end else if (redirect_valid) begin
            req_word_reg    <= redirect_pc[ADDR_W-1:OFF_W];
            out_pc_reg      <= redirect_pc;
            byte_off_reg    <= redirect_pc[OFF_W-1:0];
            // A response landing now retires the old fetch, so nothing to drop later.
            outstanding_reg <= outstanding_reg & !mem_rvalid;
            discard_reg     <= (outstanding_reg & !mem_rvalid) | grant;
        end else begin
            if (grant) begin
                outstanding_reg <= 1'b1;
                req_word_reg    <= req_word_reg + WA_W'(1);
            end else if (resp) begin
                outstanding_reg <= 1'b0;
            end
            if (resp && discard_reg) begin
                discard_reg <= 1'b0;
            end
            if (fire) begin
                out_pc_reg   <= out_pc_reg + ADDR_W'(1);
                byte_off_reg <= byte_off_reg + off_t'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_byte_streamer.sv
// Directed bench for fetch_byte_streamer with a simple single-port memory
// model whose byte at address a is ((a+1)*17) mod 256 (word 0 = 0x44332211).
module tb_fetch_byte_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [7:0]  inst;
    logic [31:0] pc;
    logic        valid;
    logic        ready;

`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;

    // memory model state
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_wait;
    int          stall_left;
    int          resp_delay;
    int          wait_cnt;
    bit          spurious;
    logic [31:0] grant_log [$];
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    fetch_byte_streamer dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .inst           (inst),
        .pc             (pc),
        .valid          (valid),
        .ready          (ready)
    );

    function automatic logic [7:0] exp_byte(input logic [31:0] a);
        logic [31:0] t;
        t = (a + 32'd1) * 32'd17;
        return t[7:0];
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {exp_byte(a + 32'd3), exp_byte(a + 32'd2), exp_byte(a + 32'd1), exp_byte(a)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: grant decided from settled mem_req, then response after the edge.
    task automatic tick();
        bit          granted;
        logic [31:0] gaddr;
        #1;
        granted = 1'b0;
        gaddr   = '0;
        mem_gnt = 1'b0;
        if (mem_req) begin
            if (stall_left > 0) begin
                stall_left--;
                wait_cnt++;
            end else begin
                mem_gnt = 1'b1;
                granted = 1'b1;
                gaddr   = mem_addr;
            end
        end
        @(posedge clk);
        #1;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (granted) begin
            grant_log.push_back(gaddr);
            pend      = 1'b1;
            pend_addr = gaddr;
            pend_wait = resp_delay;
        end
        if (pend) begin
            if (pend_wait == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(pend_addr);
                pend       = 1'b0;
            end else begin
                pend_wait--;
            end
        end else if (spurious) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEADBEEF;
            spurious   = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ready          = 1'b0;
        mem_gnt        = 1'b0;
        mem_rvalid     = 1'b0;
        mem_rdata      = '0;
        pend           = 1'b0;
        stall_left     = 0;
        resp_delay     = 0;
        spurious       = 1'b0;
        tick();
        tick();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        rst = 1'b0;
        grant_log.delete();
        wait_cnt = 0;
    endtask

    // Consume bytes until exp_pc reaches target, checking order and data.
    task automatic drain(input logic [31:0] target, input int budget, input string tag);
        for (int n = 0; n < budget && exp_pc != target; n++) begin
            if (valid && ready) begin
                $display("byte pc=%h inst=%h", pc, inst);
                check({tag, "_pc"}, pc, exp_pc);
                check({tag, "_inst"}, 32'(inst), 32'(exp_byte(exp_pc)));
                exp_pc = exp_pc + 32'd1;
            end
            tick();
        end
        check({tag, "_done"}, exp_pc, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: back-to-back stream from reset pc 0
        do_reset();
        ready = 1'b1;
        tick();
        check("t1_first_addr", grant_log[0], 32'h0);
        check("t1_latency_valid", 32'(valid), 32'(BYP));
        if (!BYP) tick();
        for (int i = 0; i < 8; i++) begin
            $display("byte pc=%h inst=%h", pc, inst);
            check("t1_valid", 32'(valid), 32'd1);
            check("t1_pc", pc, 32'(i));
            check("t1_inst", 32'(inst), 32'(exp_byte(32'(i))));
            tick();
        end

        // 2: stall decode, buffer fills with two words, then drain
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 2) begin
                check("t2_hold_pc", pc, 32'h0);
                check("t2_hold_inst", 32'(inst), 32'h11);
            end
        end
        check("t2_valid", 32'(valid), 32'd1);
        check("t2_req_off", 32'(mem_req), 32'd0);
        check("t2_grants", 32'(grant_log.size()), 32'd2);
        check("t2_addr1", grant_log[1], 32'h4);
        ready  = 1'b1;
        exp_pc = 32'h0;
        drain(32'h8, 30, "t2");

        // 3: grant withheld three cycles for the request to 0x8
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        stall_left = 3;
        wait_cnt   = 0;
        ready      = 1'b1;
        exp_pc     = 32'h0;
        for (int n = 0; n < 60 && exp_pc != 32'hC; n++) begin
            if (valid && ready) begin
                $display("byte pc=%h inst=%h", pc, inst);
                check("t3_pc", pc, exp_pc);
                check("t3_inst", 32'(inst), 32'(exp_byte(exp_pc)));
                exp_pc = exp_pc + 32'd1;
            end
            if (mem_req && grant_log.size() == 2) check("t3_addr_hold", mem_addr, 32'h8);
            tick();
        end
        check("t3_done", exp_pc, 32'hC);
        check("t3_wait_cycles", 32'(wait_cnt), 32'd3);
        check("t3_addr2", grant_log[2], 32'h8);
        begin
            int hits = 0;
            foreach (grant_log[k]) if (grant_log[k] == 32'h8) hits++;
            check("t3_one_req_8", 32'(hits), 32'd1);
        end

        // 4: redirect to unaligned 0x1006 while the fetch of 0x4 is in flight
        do_reset();
        resp_delay = 2;
        for (int n = 0; n < 20 && grant_log.size() < 2; n++) tick();
        check("t4_grants", 32'(grant_log.size()), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1006;
        #1;
        check("t4_redir_valid", 32'(valid), 32'd0);
        check("t4_redir_req", 32'(mem_req), 32'd0);
        tick();
        redirect_valid = 1'b0;
        resp_delay     = 0;
        #1;
        check("t4_still_outstanding", 32'(mem_req), 32'd0);
        check("t4_new_addr", mem_addr, 32'h1004);
        check("t4_flushed", 32'(valid), 32'd0);
        ready  = 1'b1;
        exp_pc = 32'h1006;
        drain(32'h100C, 40, "t4");
        check("t4_addr_a", grant_log[2], 32'h1004);
        check("t4_addr_b", grant_log[3], 32'h1008);

        // 5: redirect in the same cycle as a response
        do_reset();
        tick();
        check("t5_grants", 32'(grant_log.size()), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000;
        #1;
        check("t5_redir_valid", 32'(valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t5_dropped", 32'(valid), 32'd0);
        check("t5_req", 32'(mem_req), 32'd1);
        check("t5_addr", mem_addr, 32'h2000);
        ready  = 1'b1;
        exp_pc = 32'h2000;
        drain(32'h2008, 40, "t5");
        check("t5_addr1", grant_log[1], 32'h2000);

        // 6: response with nothing outstanding is ignored
        do_reset();
        ready      = 1'b1;
        stall_left = 5;
        spurious   = 1'b1;
        tick();
        tick();
        check("t6_ignored", 32'(valid), 32'd0);
        exp_pc = 32'h0;
        drain(32'h4, 40, "t6");

        // 7: pc and fetch address wrap past the top of memory
        do_reset();
        ready          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        exp_pc         = 32'hFFFF_FFFE;
        drain(32'h2, 40, "t7");
        check("t7_addr0", grant_log[0], 32'hFFFF_FFFC);
        check("t7_addr1", grant_log[1], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_byte_streamer.md
Name: fetch_byte_streamer

Overview:
Producer side of the decode byte interface. It fetches aligned 32-bit words from instruction memory, buffers them, and presents one instruction byte per cycle together with its pc to the decode phases (opcode/displacement/immediate) over a valid/ready handshake. It handles pc redirects from branch resolution by flushing its buffer and any in-flight fetch.

Parameters:
ADDR_W, 32, width of pc and memory address
BUF_WORDS, 2, depth of the word buffer, in 32-bit words (power of 2, ≥2)
RESET_PC, 0, pc loaded on reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
redirect_valid  in  1  pc redirect request (highest priority)
redirect_pc  in  ADDR_W  new pc; may be byte-unaligned
mem_req  out  1  fetch request
mem_addr  out  ADDR_W  word-aligned fetch address; bits [1:0] are always 0
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  response data valid
mem_rdata  in  32  response word, little-endian
inst  out  8  current instruction byte
pc  out  ADDR_W  address of inst
valid  out  1  inst/pc valid
ready  in  1  decoder consumes the byte

Behaviour:
- Reset (synchronous):
  - req_pc = out_pc = RESET_PC; byte_off = RESET_PC[1:0].
  - Buffer empty; outstanding = 0; discard = 0.
  - valid = 0, mem_req = 0.
- Request issue:
  - mem_req = 1 iff outstanding == 0, buf_count < BUF_WORDS, and no redirect_valid this cycle.
  - mem_addr = {req_pc[ADDR_W-1:2], 2'b00}. Address is stable while mem_req = 1 and mem_gnt = 0.
  - mem_gnt & mem_req → outstanding = 1; req_pc = aligned req_pc + 4, wrapping modulo 2^ADDR_W.
  - At most one request is outstanding at any time.
- Response:
  - mem_rvalid with outstanding = 1 → outstanding = 0.
  - If discard = 1: drop the word and clear discard. Otherwise push the word into the buffer.
  - mem_rvalid with outstanding = 0 is ignored.
- Output:
  - valid = buffer non-empty & !redirect_valid.
  - inst = head_word[8*byte_off +: 8]; pc = out_pc.
  - valid & ready → out_pc + 1 (wraps modulo 2^ADDR_W) and byte_off + 1.
  - byte_off wrapping 3→0 pops the head word.
  - While valid = 1 and ready = 0, inst and pc hold stable.
- Simultaneous push and pop: both take effect and buf_count is unchanged. Push into a full buffer cannot occur because requests are gated by buf_count.
- Redirect (any cycle, overrides everything):
  - Buffer flushed; out_pc = redirect_pc; req_pc = redirect_pc; byte_off = redirect_pc[1:0].
  - Leading bytes of the first fetched word are skipped.
  - discard = outstanding | (mem_req & mem_gnt this cycle), so the stale response is dropped.
  - A response arriving in the same cycle as the redirect is dropped and clears outstanding.
  - No byte transfer occurs in the redirect cycle.
- Latency: first valid byte appears 1 cycle after mem_rvalid (without the optional feature). Steady-state throughput is 1 byte/cycle when memory returns a word within 3 cycles of gnt.
- Reset mid-operation: return to the reset state next cycle. Any later mem_rvalid for a pre-reset request is ignored because outstanding = 0.

Optional Feature:
FETCH_BYPASS_EN.
- Defined: when the buffer is empty, a non-discarded mem_rvalid word drives inst/pc combinationally in the same cycle (valid = 1). If ready = 1, the byte is consumed and the remaining bytes are buffered. Zero-cycle response-to-byte latency.
- Undefined: response is always registered first; 1-cycle latency. No combinational path from mem_rdata to inst.

Decomposition:
- Shared package: addr_t (ADDR_W), word_t (32b), byte_t (8b), WORD_BYTES = 4, and the byte-offset width constant.
- One sub-module: fetch_word_fifo, a BUF_WORDS-deep word FIFO with push, pop, flush, count, and head output.
- The streamer owns the pc, byte offset, outstanding, and discard logic.

Test Plan:
- Reset with RESET_PC=0; mem returns 0x44332211 one cycle after gnt; ready=1 → inst 11,22,33,44 with pc 0,1,2,3 on consecutive cycles.
- ready=0 held → inst/pc stable. Buffer fills with 2 words (addr 0x0, 0x4), then mem_req=0. Raising ready drains 8 bytes in order.
- mem_gnt delayed 3 cycles → mem_req held and mem_addr stable at 0x8 throughout; exactly one response accepted.
- redirect_pc=0x1006 while request to 0x4 is outstanding → 0x4 response dropped, next mem_addr=0x1004. First byte out is rdata[23:16] with pc=0x1006, then pc=0x1007, then word 0x1008.
- redirect_valid and mem_rvalid in the same cycle → word dropped, valid=0 that cycle, outstanding cleared, next request to redirect address.
- With FETCH_BYPASS_EN and buffer empty → valid=1 and inst=rdata[7:0] in the same cycle as mem_rvalid. Without the macro → next cycle.
